// File: rtl/noc_pkg.sv
// Shared port codes, port count and arbiter FSM encoding for the NoC switch allocator.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] P1   = 3'd1;
    localparam logic [2:0] P2   = 3'd2;
    localparam logic [2:0] P3   = 3'd3;
    localparam logic [2:0] P4   = 3'd4;
    localparam logic [2:0] P5   = 3'd5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Invalid codes (0, 6, 7) map to an all-zero vector, so they can never match a request.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [2:0] code);
        logic [NUM_PORTS-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (code == 3'(i + 1)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    function automatic logic [2:0] next_port(input logic [2:0] code);
        return (code == P5) ? P1 : code + 3'd1;
    endfunction

endpackage

// File: rtl/out_arbiter.sv
// Per-output arbiter: round-robin pick of one input, then lock to it until its tail flit transfers.
module out_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] cand,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] req_tail,
    input  logic                 out_ready,
    output logic [2:0]           sa,
    output logic [NUM_PORTS-1:0] grant,
    output arb_state_e           state_dbg
);

    arb_state_e           state_q, state_d;
    logic [2:0]           owner_q, owner_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [2:0]           winner;
    logic                 found;
    logic [2:0]           scan;
    logic [NUM_PORTS-1:0] owner_hit;
    logic                 xfer;
    logic                 tail_xfer;

    // Search starts at the pointer and wraps 5 -> 1; the first candidate seen wins.
    always_comb begin
        winner = NONE;
        found  = 1'b0;
        scan   = ptr_q;
        for (int off = 0; off < NUM_PORTS; off++) begin
            if (!found && |(cand & port_onehot(scan))) begin
                winner = scan;
                found  = 1'b1;
            end
            scan = next_port(scan);
        end
    end

    always_comb begin
        owner_hit = port_onehot(owner_q);
        xfer      = (state_q == ST_LOCKED) && |(req_valid & owner_hit) && out_ready;
        tail_xfer = xfer && |(req_tail & owner_hit);
        grant     = xfer ? owner_hit : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LOCKED;
                    owner_d = winner;
                end
            end
            ST_LOCKED: begin
                if (tail_xfer) begin
                    state_d = ST_IDLE;
                    owner_d = NONE;
                    ptr_d   = next_port(owner_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= NONE;
            ptr_q   <= P1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Owner is cleared on release, so the register alone carries the IDLE/LOCKED view of sa.
    assign sa        = owner_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/switch_allocator.sv
// Five-output switch allocator: fans each input's request to its target output arbiter and ORs the grants.
module switch_allocator
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [2:0]           dst1,
    input  logic [2:0]           dst2,
    input  logic [2:0]           dst3,
    input  logic [2:0]           dst4,
    input  logic [2:0]           dst5,
    input  logic [NUM_PORTS-1:0] req_tail,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [2:0]           sa1,
    output logic [2:0]           sa2,
    output logic [2:0]           sa3,
    output logic [2:0]           sa4,
    output logic [2:0]           sa5,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] dbg_locked
);

    // Handshake: a head flit of input i moves in a cycle when req_valid[i-1] and
    // out_ready of its locked output are both high; grant[i-1] reports exactly that cycle.

    logic [2:0]           dst_arr   [NUM_PORTS];
    logic [2:0]           sa_arr    [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand      [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_arr [NUM_PORTS];
    arb_state_e           state_arr [NUM_PORTS];

    assign dst_arr[0] = dst1;
    assign dst_arr[1] = dst2;
    assign dst_arr[2] = dst3;
    assign dst_arr[3] = dst4;
    assign dst_arr[4] = dst5;

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[k][i] = req_valid[i] && (dst_arr[i] == 3'(k + 1));
            end
        end
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_out
        out_arbiter u_arb (
            .clk       (clk),
            .rst       (rst),
            .cand      (cand[k]),
            .req_valid (req_valid),
            .req_tail  (req_tail),
            .out_ready (out_ready[k]),
            .sa        (sa_arr[k]),
            .grant     (grant_arr[k]),
            .state_dbg (state_arr[k])
        );
        assign dbg_locked[k] = (state_arr[k] == ST_LOCKED);
    end

    always_comb begin
        grant = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            grant = grant | grant_arr[k];
        end
    end

    assign sa1 = sa_arr[0];
    assign sa2 = sa_arr[1];
    assign sa3 = sa_arr[2];
    assign sa4 = sa_arr[3];
    assign sa5 = sa_arr[4];

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port req_valid, input, 5 bits: bit i-1 set means input port i has a flit at its buffer head.
REQ-004 SHALL have ports dst1..dst5, input, 3 bits each: requested output port of input i's head flit; 3'b001..3'b101 select outputs 1..5; 0, 6 and 7 are invalid.
REQ-005 SHALL have port req_tail, input, 5 bits: bit i-1 set means input i's head flit is a tail flit.
REQ-006 SHALL have port out_ready, input, 5 bits: bit k-1 set means output k can accept one flit this cycle.
REQ-007 SHALL have ports sa1..sa5, output, 3 bits each: input port owning output k (3'b001..3'b101); 3'b000 means none.
REQ-008 SHALL have port grant, output, 5 bits: bit i-1 set means input i's head flit transfers this cycle.

Function
REQ-009 SHALL hold one 2-state FSM per output: IDLE and LOCKED.
REQ-010 SHALL treat input i as a candidate for output k only when req_valid[i-1]=1 and dst_i=k; invalid dst codes SHALL never request.
REQ-011 SHALL, in IDLE with at least one candidate, select by round-robin: search order starts at ptr_k, wraps 5->1, first candidate wins.
REQ-012 SHALL register the winner as owner_k and enter LOCKED at the next edge; arbitration latency is 1 cycle.
REQ-013 SHALL drive sa_k = owner_k while LOCKED and 3'b000 while IDLE; sa_k is a direct register output with no combinational path from inputs.
REQ-014 SHALL count a transfer on output k in a cycle where it is LOCKED, req_valid[owner_k-1]=1 and out_ready[k-1]=1; grant[owner_k-1] SHALL equal that condition.
REQ-015 SHALL, on a transfer with req_tail[owner_k-1]=1, return to IDLE at the next edge and set ptr_k = owner_k+1, wrapping 5->1.
REQ-016 SHALL stay LOCKED with owner unchanged across bubbles (owner valid=0) and back-pressure (out_ready=0); a change of dst by the owner while LOCKED SHALL be ignored.
REQ-017 SHALL spend at least one IDLE cycle between packets on the same output; no re-arbitration in the release cycle.
REQ-018 SHALL allow all five outputs to arbitrate independently in the same cycle; each input requests only one output, so no input is granted by two outputs.
REQ-019 SHALL hold ptr_k unchanged when IDLE has no candidates.
REQ-020 SHALL keep grant purely combinational from state, req_valid and out_ready (zero-latency handshake).
REQ-021 SHALL treat a single-flit packet (head is tail) as a transfer followed by release.

Reset
REQ-022 SHALL, on rst=1, force every FSM to IDLE, owner_k=0 and ptr_k=1, which drives sa1..sa5=0 and grant=0 from the following cycle.
REQ-023 SHALL let rst asserted mid-packet drop every lock without waiting for a tail.
REQ-024 SHALL give rst priority over every other event in the same cycle.

Structure
REQ-025 SHALL place the port-code constants (NONE=0, P1..P5=1..5), the port count 5 and the FSM state encoding in a shared package, noc_pkg.
REQ-026 SHALL instantiate five copies of one sub-module, out_arbiter (FSM, round-robin pointer, owner register), one per output; the top level only fans requests out and ORs the grants.

Verification
REQ-027 Reset: rst=1 with all requests active -> sa1..sa5=0 and grant=0 the next cycle; ptr=1 on every output.
REQ-028 Contention: inputs 2 and 4 request output 3 in cycle 0 with ptr3=1 -> sa3=2 in cycle 1; after input 2's tail transfers, sa3=0 for one cycle, then sa3=4.
REQ-029 Wrap-around fairness: inputs 1 and 5 continuously request output 2, with 1-flit packets -> sa2 alternates 1,0,5,0,1 and neither input starves.
REQ-030 Back-pressure: owner 3 on output 1 holds a 3-flit packet with out_ready[0]=0 for 4 cycles -> grant[2]=0 and sa1=3 held; 3 grants after ready returns, then release.
REQ-031 Parallel and invalid: inputs 1..5 request outputs 5,4,3,2,1 in one cycle -> all sa set in the next cycle; dst=6 on any input -> no grant.
REQ-032 Reset mid-packet: rst=1 while output 4 is locked by input 1 without a tail -> sa4=0 next cycle; input 1 re-arbitrates afterwards.
